// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/sub front end:
// class bit indices, format width derivation and the canonical quiet NaN.
package fp_pkg;

    localparam int unsigned CLS_ZERO = 0;
    localparam int unsigned CLS_SUB  = 1;
    localparam int unsigned CLS_NORM = 2;
    localparam int unsigned CLS_INF  = 3;
    localparam int unsigned CLS_QNAN = 4;
    localparam int unsigned CLS_SNAN = 5;
    localparam int unsigned CLS_W    = 6;

    // Widest format the helpers below can build; callers truncate to W.
    localparam int unsigned MAX_W = 128;

    function automatic int unsigned fp_width(input int unsigned exp_w,
                                             input int unsigned frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    // Sign 0, exponent all-ones, fraction MSB set: exp_w+1 ones starting at bit frac_w-1.
    function automatic logic [MAX_W-1:0] canon_qnan(input int unsigned exp_w,
                                                    input int unsigned frac_w);
        return ((MAX_W'(1) << (exp_w + 1)) - MAX_W'(1)) << (frac_w - 1);
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational single-operand classifier; emits a one-hot IEEE-754 class.
module fp_classify
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic [EXP_W-1:0]  exp,
    input  logic [FRAC_W-1:0] frac,
    output logic [CLS_W-1:0]  cls_c
);

    always_comb begin
        cls_c = '0;
        if (exp == '0) begin
            if (frac == '0) cls_c[CLS_ZERO] = 1'b1;
            else            cls_c[CLS_SUB]  = 1'b1;
        end else if (&exp) begin
            if (frac == '0)             cls_c[CLS_INF]  = 1'b1;
            else if (frac[FRAC_W-1])    cls_c[CLS_QNAN] = 1'b1;
            else                        cls_c[CLS_SNAN] = 1'b1;
        end else begin
            cls_c[CLS_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_special_classify_pipe.sv
// Two-stage operand classifier and special-case resolver for the add/sub path,
// with a sticky invalid flag and a saturating special-result counter.
module fp_special_classify_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned W     = fp_width(EXP_W, FRAC_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CLS_W-1:0] cls_a,
    output logic [CLS_W-1:0] cls_b,
    output logic             special,
    output logic [W-1:0]     special_res,
    output logic             invalid,
    output logic             invalid_sticky,
    input  logic             flag_clr,
    output logic [CNT_W-1:0] spec_cnt
);

    localparam logic [W-1:0] QNAN    = W'(canon_qnan(EXP_W, FRAC_W));
    localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {FRAC_W{1'b0}}};

    logic             s1_valid;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic             s1_sub;
    logic [CLS_W-1:0] s1_cls_a;
    logic [CLS_W-1:0] s1_cls_b;

    logic [CLS_W-1:0] cls_a_c;
    logic [CLS_W-1:0] cls_b_c;
    logic             s2_load_c;
    logic             xfer_c;
    logic             res_special_c;
    logic             res_invalid_c;
    logic [W-1:0]     res_val_c;

    fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_a (
        .exp   (a[W-2 -: EXP_W]),
        .frac  (a[FRAC_W-1:0]),
        .cls_c (cls_a_c)
    );

    fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_b (
        .exp   (b[W-2 -: EXP_W]),
        .frac  (b[FRAC_W-1:0]),
        .cls_c (cls_b_c)
    );

    // Each stage loads when empty or when its contents leave this cycle.
    assign s2_load_c = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load_c;
    assign xfer_c    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sub   <= 1'b0;
            s1_cls_a <= '0;
            s1_cls_b <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            s1_a     <= a;
            s1_b     <= b;
            s1_sub   <= op_sub;
            s1_cls_a <= cls_a_c;
            s1_cls_b <= cls_b_c;
        end
    end

    // IEEE special-case resolution, highest priority first.
    always_comb begin
        logic sa;
        logic sb_eff;
        logic nan_a;
        logic nan_b;
        sa            = s1_a[W-1];
        sb_eff        = s1_b[W-1] ^ s1_sub;
        nan_a         = s1_cls_a[CLS_QNAN] || s1_cls_a[CLS_SNAN];
        nan_b         = s1_cls_b[CLS_QNAN] || s1_cls_b[CLS_SNAN];
        res_special_c = 1'b1;
        res_invalid_c = 1'b0;
        res_val_c     = '0;
        if (nan_a || nan_b) begin
            res_val_c     = QNAN;
            res_invalid_c = s1_cls_a[CLS_SNAN] || s1_cls_b[CLS_SNAN];
        end else if (s1_cls_a[CLS_INF] && s1_cls_b[CLS_INF] && (sa != sb_eff)) begin
            res_val_c     = QNAN;
            res_invalid_c = 1'b1;
        end else if (s1_cls_a[CLS_INF]) begin
            res_val_c = {sa, INF_MAG};
        end else if (s1_cls_b[CLS_INF]) begin
            res_val_c = {sb_eff, INF_MAG};
        end else if (s1_cls_a[CLS_ZERO] && s1_cls_b[CLS_ZERO]) begin
            res_val_c = {sa & sb_eff, {(W-1){1'b0}}};
        end else if (s1_cls_a[CLS_ZERO]) begin
            res_val_c = {sb_eff, s1_b[W-2:0]};
        end else if (s1_cls_b[CLS_ZERO]) begin
            res_val_c = s1_a;
        end else begin
            res_special_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            cls_a       <= '0;
            cls_b       <= '0;
            special     <= 1'b0;
            special_res <= '0;
            invalid     <= 1'b0;
        end else if (s2_load_c) begin
            out_valid   <= s1_valid;
            cls_a       <= s1_cls_a;
            cls_b       <= s1_cls_b;
            special     <= res_special_c;
            special_res <= res_val_c;
            invalid     <= res_invalid_c;
        end
    end

    // A setting transfer wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            invalid_sticky <= 1'b0;
            spec_cnt       <= '0;
        end else begin
            if (xfer_c && invalid)  invalid_sticky <= 1'b1;
            else if (flag_clr)      invalid_sticky <= 1'b0;

            if (xfer_c && special) begin
                if (flag_clr)              spec_cnt <= CNT_W'(1);
                else if (spec_cnt != '1)   spec_cnt <= spec_cnt + CNT_W'(1);
            end else if (flag_clr) begin
                spec_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fp_special_classify_pipe.sv
// Directed bench for fp_special_classify_pipe: special-case vectors, stall
// stream, counter saturation, clear collision and mid-flight reset.
module tb_fp_special_classify_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        op_sub;
    logic        out_ready;
    logic        flag_clr;

    logic        in_ready, out_valid, special, invalid, invalid_sticky;
    logic [5:0]  cls_a, cls_b;
    logic [31:0] special_res;
    logic [15:0] spec_cnt;

    logic        c2_in_ready, c2_out_valid, c2_special, c2_invalid, c2_invalid_sticky;
    logic [5:0]  c2_cls_a, c2_cls_b;
    logic [31:0] c2_special_res;
    logic [1:0]  c2_spec_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_special_classify_pipe #(.EXP_W(8), .FRAC_W(23), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
        .cls_a(cls_a), .cls_b(cls_b), .special(special), .special_res(special_res),
        .invalid(invalid), .invalid_sticky(invalid_sticky), .flag_clr(flag_clr),
        .spec_cnt(spec_cnt)
    );

    fp_special_classify_pipe #(.EXP_W(8), .FRAC_W(23), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c2_in_ready),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(c2_out_valid), .out_ready(out_ready),
        .cls_a(c2_cls_a), .cls_b(c2_cls_b), .special(c2_special),
        .special_res(c2_special_res), .invalid(c2_invalid),
        .invalid_sticky(c2_invalid_sticky), .flag_clr(flag_clr), .spec_cnt(c2_spec_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one pair at a negedge and return at the negedge where its result is visible.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        a = av; b = bv; op_sub = sv; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 0; n < 4 && !out_valid; n++) @(negedge clk);
        check("send_out_valid", 64'(out_valid), 64'd1);
    endtask

    logic [31:0] svec [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0;
        out_ready = 1'b1; flag_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_cls", 64'({cls_a, cls_b}), 64'd0);
        check("rst_special", 64'({special, invalid, invalid_sticky}), 64'd0);
        check("rst_res", 64'(special_res), 64'd0);
        check("rst_cnt", 64'(spec_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // inf - inf
        send(32'h7F800000, 32'h7F800000, 1'b1);
        check("infinf_cls_a", 64'(cls_a), 64'b001000);
        check("infinf_cls_b", 64'(cls_b), 64'b001000);
        check("infinf_special", 64'(special), 64'd1);
        check("infinf_res", 64'(special_res), 64'h7FC00000);
        check("infinf_invalid", 64'(invalid), 64'd1);
        check("infinf_sticky_pre", 64'(invalid_sticky), 64'd0);
        @(negedge clk);
        check("infinf_sticky", 64'(invalid_sticky), 64'd1);
        check("infinf_drained", 64'(out_valid), 64'd0);

        // sNaN + 1.0
        send(32'h7FA00000, 32'h3F800000, 1'b0);
        check("snan_cls_a", 64'(cls_a), 64'b100000);
        check("snan_cls_b", 64'(cls_b), 64'b000100);
        check("snan_res", 64'(special_res), 64'h7FC00000);
        check("snan_invalid", 64'(invalid), 64'd1);

        // -0 - +0 and -0 + +0
        send(32'h80000000, 32'h00000000, 1'b1);
        check("zz_sub_res", 64'(special_res), 64'h80000000);
        check("zz_sub_invalid", 64'(invalid), 64'd0);
        send(32'h80000000, 32'h00000000, 1'b0);
        check("zz_add_res", 64'(special_res), 64'h00000000);
        check("zz_add_special", 64'(special), 64'd1);

        // subnormal + pi
        send(32'h00000001, 32'h40490FDB, 1'b0);
        check("sub_cls_a", 64'(cls_a), 64'b000010);
        check("sub_special", 64'(special), 64'd0);
        check("sub_res", 64'(special_res), 64'd0);

        // one-zero and finite - inf cases
        send(32'h00000000, 32'h3F800000, 1'b1);
        check("za_res", 64'(special_res), 64'hBF800000);
        send(32'h40000000, 32'h80000000, 1'b0);
        check("zb_res", 64'(special_res), 64'h40000000);
        send(32'h3F800000, 32'h7F800000, 1'b1);
        check("infb_res", 64'(special_res), 64'hFF800000);
        check("infb_invalid", 64'(invalid), 64'd0);
        send(32'hFF800000, 32'h7F800000, 1'b1);
        check("infinf_same_res", 64'(special_res), 64'hFF800000);
        @(negedge clk);
        check("cnt_before_clr", 64'(spec_cnt), 64'd8);

        // Clear alone, then 5 special transfers
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        check("clr_sticky", 64'(invalid_sticky), 64'd0);
        check("clr_cnt", 64'(spec_cnt), 64'd0);
        for (int k = 0; k < 5; k++) begin
            send(32'h7F800000, 32'h3F800000, 1'b0);
            check("inf_plus_one_res", 64'(special_res), 64'h7F800000);
        end
        @(negedge clk);
        check("cnt16_five", 64'(spec_cnt), 64'd5);
        check("cnt2_saturate", 64'(c2_spec_cnt), 64'd3);
        check("sticky_clean", 64'(invalid_sticky), 64'd0);

        // Clear coincident with an invalid special transfer
        send(32'h7F800000, 32'h7F800000, 1'b1);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        check("coll_sticky", 64'(invalid_sticky), 64'd1);
        check("coll_cnt", 64'(spec_cnt), 64'd1);
        check("coll_cnt_c2", 64'(c2_spec_cnt), 64'd1);

        // Stream of 8 with out_ready low in cycles 3..5
        begin
            int i = 0;
            int j = 0;
            int first = -1;
            logic [31:0] held = '0;
            logic prev_stall = 1'b0;
            logic saw_block = 1'b0;
            for (int c = 0; c < 40 && j < 8; c++) begin
                out_ready = !(c >= 3 && c <= 5);
                if (i < 8) begin
                    a = 32'h0; b = svec[i]; op_sub = 1'b0; in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (prev_stall) check("stall_hold", 64'(special_res), 64'(held));
                if (out_valid && first < 0) first = c;
                if (c >= 3 && c <= 5 && !in_ready) saw_block = 1'b1;
                if (out_valid && out_ready) begin
                    check("stream_data", 64'(special_res), 64'(svec[j]));
                    j++;
                end
                prev_stall = out_valid && !out_ready;
                held = special_res;
                if (in_valid && in_ready) i++;
                @(negedge clk);
            end
            in_valid = 1'b0;
            check("stream_count", 64'(j), 64'd8);
            check("stream_latency", 64'(first), 64'd2);
            check("stream_blocked", 64'(saw_block), 64'd1);
            @(negedge clk);
            check("stream_no_dup", 64'(out_valid), 64'd0);
        end

        // Reset with both stages full
        out_ready = 1'b0;
        a = 32'h0; b = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_cnt", 64'(spec_cnt), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        begin
            logic seen = 1'b0;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check("midrst_no_ghost", 64'(seen), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_special_classify_pipe.md
# fp_special_classify_pipe

Parametrised, pipelined operand classifier and special-case resolver for the IEEE-754 add/sub datapath. It sits between operand capture and the alignment stage. Each cycle it accepts one operand pair with an add/sub opcode, classifies both operands, and returns a registered result. When IEEE rules fix the result (NaN, infinity, zero), it supplies that result so the mantissa datapath can be bypassed. It also keeps a sticky invalid flag and a saturating count of special-case events.

## Interface
Parameters:
- EXP_W, 8, exponent field width (≥2)
- FRAC_W, 23, fraction field width (≥2)
- CNT_W, 16, width of the special-event counter
- Derived W = 1 + EXP_W + FRAC_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- in_valid  in  1  input pair valid
- in_ready  out  1  block can accept the pair this cycle
- a, b  in  W  operands {sign, exp, frac}
- op_sub  in  1  1 = a − b, 0 = a + b
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- cls_a, cls_b  out  6  one-hot class: [0] zero, [1] subnormal, [2] normal, [3] inf, [4] qNaN, [5] sNaN
- special  out  1  result fully determined here
- special_res  out  W  result when special=1, else 0
- invalid  out  1  this result raises IEEE invalid
- invalid_sticky  out  1  OR of all invalid results since last clear
- flag_clr  in  1  clears invalid_sticky and spec_cnt
- spec_cnt  out  CNT_W  saturating count of delivered results with special=1

## Operation
- Classification is per operand. Let e = exponent field and f = fraction field.
  - zero: e=0, f=0, either sign.
  - subnormal: e=0, f≠0.
  - inf: e all-ones, f=0.
  - qNaN: e all-ones, f[FRAC_W−1]=1.
  - sNaN: e all-ones, f≠0, f[FRAC_W−1]=0.
  - normal: all other encodings.
- Effective sign of b is sb_eff = b.sign ^ op_sub.
- Resolution rules, in priority order:
  1. Either operand is a NaN → special=1, special_res = canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0). invalid=1 if either operand is sNaN.
  2. Both operands are inf with sa≠sb_eff → canonical qNaN, invalid=1.
  3. Either operand is inf → special=1, special_res = ±inf with that operand's effective sign.
  4. Both operands are zero → special_res = {sa & sb_eff, 0…}.
  5. Exactly one operand is zero → special_res = the other operand, with sb_eff substituted when the other operand is b.
  6. Otherwise special=0, special_res=0, invalid=0.
- invalid_sticky sets when a result with invalid=1 transfers (out_valid & out_ready).
- spec_cnt increments on each transfer with special=1 and saturates at all-ones.
- If flag_clr asserts in the same cycle as a setting or incrementing transfer, the set/increment wins: sticky=1 and cnt=1, the latter only when the transfer has special=1.

## Timing
- Two register stages:
  - S1 registers operands, opcode, cls_a and cls_b.
  - S2 registers resolution outputs.
- Latency: 2 cycles from input accept to out_valid.
- Throughput: 1 pair per cycle when out_ready=1.
- Each stage loads when it is empty or its contents advance this cycle.
- in_ready = !s1_valid | s2 loads. This is combinational from out_ready, with no combinational path from in_valid.
- With out_valid=1 and out_ready=0, all outputs hold stable, and in_ready drops once S1 is also full.
- Reset values: out_valid=0, in_ready=1, and cls_a, cls_b, special, special_res, invalid, invalid_sticky and spec_cnt all 0.
- Reset mid-operation discards in-flight pairs. No output transfer is generated for them.

## Structure
- The shared package fp_pkg holds:
  - class index localparams (CLS_ZERO … CLS_SNAN);
  - a function returning the canonical qNaN for given EXP_W/FRAC_W;
  - the W derivation.
- Sub-module fp_classify: a purely combinational, parametrised single-operand classifier producing the 6-bit one-hot. It is instantiated twice, feeding S1.
- Resolution logic and flag/counter logic live in the top module.

## Test plan
- Defaults throughout: EXP_W=8, FRAC_W=23.
- a=0x7F800000, b=0x7F800000, op_sub=1 → cls_a=cls_b=6'b001000, special=1, special_res=0x7FC00000, invalid=1, invalid_sticky=1 one cycle after the transfer.
- a=0x7FA00000 (sNaN), b=0x3F800000, op_sub=0 → cls_a=6'b100000, cls_b=6'b000100, special_res=0x7FC00000, invalid=1.
- a=0x80000000, b=0x00000000, op_sub=1 → special_res=0x80000000; with op_sub=0 → 0x00000000; invalid=0.
- a=0x00000001, b=0x40490FDB, op_sub=0 → cls_a=subnormal, special=0, special_res=0.
- Back-to-back stream of 8 pairs with out_ready low for cycles 3–5:
  - no loss or duplication;
  - order preserved;
  - outputs stable while stalled;
  - in_ready=0 once both stages are full;
  - latency 2 when unstalled.
- CNT_W=2 with 5 special transfers → spec_cnt saturates at 3.
- flag_clr coincident with an invalid transfer → invalid_sticky=1, spec_cnt=1.
- rst_n low with both stages full → out_valid=0 next cycle.
